// File: rtl/bayer_window_7x7.sv
// Bayer 7x7 window generator: buffers six prior lines and emits one
// 7x7 neighbourhood per interior centre pixel, with coordinates and CFA
// parity, one cycle after the pixel that completes it is accepted.

// One line memory: combinational read, write on the clock edge, so a read
// and a write at the same address in one cycle return the old contents.
module bayer_window_7x7_lbuf #(
    parameter int DEPTH = 1920,
    parameter int DW    = 10,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Store the pixel for this column, replacing the one just read.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

module bayer_window_7x7 #(
    parameter  int IMG_WIDTH  = 1920,
    parameter  int IMG_HEIGHT = 1080,
    parameter  int DW         = 10,
    localparam int XW         = $clog2(IMG_WIDTH),
    localparam int YW         = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [DW-1:0]    in_pix,
    output logic             out_valid,
    output logic [49*DW-1:0] out_win,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic [1:0]       out_phase,
    output logic             out_eof,
    output logic             frame_overrun
);
    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_OVERRUN  = 2'd2;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_GATE = XW'(6);
    localparam logic [YW-1:0] Y_GATE = YW'(6);

    logic [1:0]    state;
    logic [XW-1:0] x_cnt;     // column of the next expected pixel
    logic [YW-1:0] y_cnt;     // row of the next expected pixel
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          accept;
    logic          emit;
    logic          x_last;
    logic          y_last;

    logic [DW-1:0] lb_rd [6];
    logic [DW-1:0] lb_wd [6];
    logic [DW-1:0] new_col [7];

    // Window as [row][col][bits]; packing order matches the out_win layout.
    logic [6:0][6:0][DW-1:0] col_q;
    logic [6:0][6:0][DW-1:0] col_d;

    // A start-of-frame pixel is always p(0,0), whatever the counters say.
    assign cur_x  = in_sof ? '0 : x_cnt;
    assign cur_y  = in_sof ? '0 : y_cnt;
    assign accept = in_valid && (in_sof || state == ST_ACTIVE);
    assign x_last = (cur_x == X_LAST);
    assign y_last = (cur_y == Y_LAST);
    // The x/y gate keeps line-wrap columns and previous-frame rows out.
    assign emit   = in_valid && !in_sof && state == ST_ACTIVE &&
                    cur_x >= X_GATE && cur_y >= Y_GATE;

    // Six chained line memories: LB1 takes the new pixel, each later one
    // takes what its predecessor held, so LBk[x] is p(x, y-k).
    for (genvar k = 0; k < 6; k++) begin : g_lb
        if (k == 0) begin : g_first
            assign lb_wd[k] = in_pix;
        end else begin : g_rest
            assign lb_wd[k] = lb_rd[k-1];
        end
        bayer_window_7x7_lbuf #(
            .DEPTH (IMG_WIDTH),
            .DW    (DW),
            .AW    (XW)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (cur_x),
            .wdata (lb_wd[k]),
            .rdata (lb_rd[k])
        );
    end

    // Next window: shift one column left, new column (oldest row on top) at c=7.
    always_comb begin
        for (int r = 0; r < 6; r++) new_col[r] = lb_rd[5-r];
        new_col[6] = in_pix;
        col_d = col_q;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 6; c++) col_d[r][c] = col_q[r][c+1];
            col_d[r][6] = new_col[r];
        end
    end

    // Column register advances on every accepted pixel.
    always_ff @(posedge clk) begin
        if (accept) col_q <= col_d;
    end

    // Frame tracking: raster counters, state, and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_WAIT_SOF;
            x_cnt         <= '0;
            y_cnt         <= '0;
            frame_overrun <= 1'b0;
        end else begin
            if (accept) begin
                state <= (x_last && y_last) ? ST_OVERRUN : ST_ACTIVE;
                x_cnt <= x_last ? '0 : cur_x + XW'(1);
                y_cnt <= x_last ? cur_y + YW'(1) : cur_y;
            end
            if (in_valid && in_sof)
                frame_overrun <= 1'b0;
            else if (in_valid && state == ST_OVERRUN)
                frame_overrun <= 1'b1;
        end
    end

    // Output stage: one-cycle pulse, data held between windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            out_win   <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_valid <= emit;
            out_eof   <= emit && x_last && y_last;
            if (emit) begin
                out_win <= col_d;
                out_x   <= cur_x - XW'(3);
                out_y   <= cur_y - YW'(3);
            end
        end
    end

    assign out_phase = {out_y[0], out_x[0]};

endmodule

// File: tb/tb_bayer_window_7x7.sv
// Bench for bayer_window_7x7 on a 16x12 frame: a frame-image model builds
// each expected window straight from the pixels sent.
module tb_bayer_window_7x7;
    localparam int W  = 16;
    localparam int H  = 12;
    localparam int DW = 10;
    localparam int WW = 49 * DW;
    typedef logic [WW-1:0] wv_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [DW-1:0]    in_pix = '0;
    logic             out_valid;
    logic [WW-1:0]    out_win;
    logic [3:0]       out_x;
    logic [3:0]       out_y;
    logic [1:0]       out_phase;
    logic             out_eof;
    logic             frame_overrun;

    bayer_window_7x7 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_pix        (in_pix),
        .out_valid     (out_valid),
        .out_win       (out_win),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_phase     (out_phase),
        .out_eof       (out_eof),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] img [H][W];
    int  nwin, neof;
    int  first_x, first_y, last_x, last_y;
    wv_t first_win, last_win;
    logic [1:0] first_ph;

    task automatic chk(input string tag, input wv_t got, input wv_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] tap(input wv_t w, input int r, input int c);
        return w[((r-1)*7+(c-1))*DW +: DW];
    endfunction

    // Window centred at (x-3, y-3) read directly out of the frame image.
    function automatic wv_t ref_win(input int x, input int y);
        wv_t w = '0;
        for (int r = 1; r <= 7; r++)
            for (int c = 1; c <= 7; c++)
                w[((r-1)*7+(c-1))*DW +: DW] = img[y-7+r][x-7+c];
        return w;
    endfunction

    // One clock with the given inputs; outputs sampled on the falling edge.
    task automatic tick(input logic v, input logic s, input logic [DW-1:0] p);
        in_valid = v; in_sof = s; in_pix = p;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    // Pixels with no start-of-frame: must never produce a window.
    task automatic send_stray(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, DW'($urandom_range(0, 1023)));
            chk("stray_valid", wv_t'(out_valid), wv_t'(0));
        end
    endtask

    // Send the first npix pixels of a frame (base<0: random values).
    task automatic send_frame(input int base, input int max_gap, input int npix);
        int x, y, e;
        logic [DW-1:0] v;
        nwin = 0; neof = 0;
        for (int i = 0; i < npix; i++) begin
            x = i % W; y = i / W;
            v = (base < 0) ? DW'($urandom_range(0, 1023)) : DW'(base + y*W + x);
            img[y][x] = v;
            repeat ($urandom_range(0, max_gap)) begin
                tick(1'b0, 1'b0, '0);
                chk("gap_valid", wv_t'(out_valid), wv_t'(0));
            end
            tick(1'b1, i == 0, v);
            e = (x >= 6 && y >= 6) ? 1 : 0;
            chk("valid", wv_t'(out_valid), wv_t'(e));
            chk("overrun_in_frame", wv_t'(frame_overrun), wv_t'(0));
            if (e != 0) begin
                chk("win", out_win, ref_win(x, y));
                chk("out_x", wv_t'(out_x), wv_t'(x-3));
                chk("out_y", wv_t'(out_y), wv_t'(y-3));
                chk("phase", wv_t'(out_phase), wv_t'({1'(y-3), 1'(x-3)}));
                chk("eof", wv_t'(out_eof), wv_t'((x == W-1 && y == H-1) ? 1 : 0));
                if (nwin == 0) begin
                    first_x = int'(out_x); first_y = int'(out_y);
                    first_win = out_win; first_ph = out_phase;
                end
                last_x = int'(out_x); last_y = int'(out_y); last_win = out_win;
                nwin++;
                if (out_eof) neof++;
            end else begin
                chk("eof_idle", wv_t'(out_eof), wv_t'(0));
            end
        end
    endtask

    // Fixed anchor values for a full frame of p(x,y)=y*16+x.
    task automatic check_ramp_frame(input string tag);
        chk({tag, "_nwin"},  wv_t'(nwin), wv_t'(60));
        chk({tag, "_neof"},  wv_t'(neof), wv_t'(1));
        chk({tag, "_fx"},    wv_t'(first_x), wv_t'(3));
        chk({tag, "_fy"},    wv_t'(first_y), wv_t'(3));
        chk({tag, "_fph"},   wv_t'(first_ph), wv_t'(3));
        chk({tag, "_d11"},   wv_t'(tap(first_win, 1, 1)), wv_t'(0));
        chk({tag, "_d44"},   wv_t'(tap(first_win, 4, 4)), wv_t'(51));
        chk({tag, "_d77"},   wv_t'(tap(first_win, 7, 7)), wv_t'(102));
        chk({tag, "_d17"},   wv_t'(tap(first_win, 1, 7)), wv_t'(6));
        chk({tag, "_lx"},    wv_t'(last_x), wv_t'(12));
        chk({tag, "_ly"},    wv_t'(last_y), wv_t'(8));
        chk({tag, "_ld44"},  wv_t'(tap(last_win, 4, 4)), wv_t'(140));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, wv_t'(out_valid), wv_t'(0));
        chk({tag, "_win"},   out_win, wv_t'(0));
        chk({tag, "_x"},     wv_t'(out_x), wv_t'(0));
        chk({tag, "_y"},     wv_t'(out_y), wv_t'(0));
        chk({tag, "_phase"}, wv_t'(out_phase), wv_t'(0));
        chk({tag, "_eof"},   wv_t'(out_eof), wv_t'(0));
        chk({tag, "_ovr"},   wv_t'(frame_overrun), wv_t'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nothing happens before the first start-of-frame.
        send_stray(20);

        // Continuous ramp frame.
        send_frame(0, 0, W*H);
        check_ramp_frame("cont");

        // Overrun: pixels past the end of the frame are dropped and flagged.
        tick(1'b1, 1'b0, DW'(7));
        chk("ovr_valid", wv_t'(out_valid), wv_t'(0));
        chk("ovr_set", wv_t'(frame_overrun), wv_t'(1));
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, DW'(i));
            chk("ovr_valid", wv_t'(out_valid), wv_t'(0));
            chk("ovr_hold", wv_t'(frame_overrun), wv_t'(1));
        end

        // Same ramp with random gaps; first sof pixel also clears overrun.
        send_frame(0, 3, W*H);
        check_ramp_frame("gaps");

        // Random pixel data with gaps.
        send_frame(-1, 3, W*H);
        chk("rand_nwin", wv_t'(nwin), wv_t'(60));

        // Mid-frame restart at p(5,8).
        send_frame(0, 1, 8*W + 5);
        send_frame(500, 2, W*H);
        chk("restart_nwin", wv_t'(nwin), wv_t'(60));
        chk("restart_fx", wv_t'(first_x), wv_t'(3));
        chk("restart_fy", wv_t'(first_y), wv_t'(3));
        chk("restart_d44", wv_t'(tap(first_win, 4, 4)), wv_t'(551));
        chk("restart_d11", wv_t'(tap(first_win, 1, 1)), wv_t'(500));

        // Asynchronous reset while windows are flowing (just before p(9,7)).
        send_frame(0, 0, 7*W + 9);
        chk("pre_reset_valid", wv_t'(out_valid), wv_t'(1));
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send_stray(20);
        chk("post_rst_ovr", wv_t'(frame_overrun), wv_t'(0));
        send_frame(0, 0, W*H);
        check_ramp_frame("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
